// File: rtl/lpc_stream_copier_if.sv
// Signal bundle between the CPU command exports, the copier and the two streaming masters.
// The master modport is the copier's view; slave is the environment (CPU PIOs and masters).
interface lpc_stream_copier_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64
);
  logic                          rm_fixed_location;
  logic [31:0]                   rm_read_base;
  logic [31:0]                   rm_read_length;
  logic                          rm_go;
  logic                          rm_done;

  logic                          wm_fixed_location;
  logic [31:0]                   wm_write_base;
  logic [31:0]                   wm_write_length;
  logic                          wm_go;
  logic                          wm_done;

  logic                          rdm_fixed_location;
  logic [31:0]                   rdm_read_base;
  logic [31:0]                   rdm_read_length;
  logic                          rdm_go;
  logic                          rdm_done;
  logic                          rdm_early_done;
  logic                          rdm_read_buffer;
  logic [DATA_WIDTH-1:0]         rdm_buffer_output_data;
  logic                          rdm_data_available;

  logic                          wrm_fixed_location;
  logic [31:0]                   wrm_write_base;
  logic [31:0]                   wrm_write_length;
  logic                          wrm_go;
  logic                          wrm_done;
  logic                          wrm_write_buffer;
  logic [DATA_WIDTH-1:0]         wrm_buffer_input_data;
  logic                          wrm_buffer_full;

  logic [$clog2(FIFO_DEPTH):0]   fifo_used;

  modport master (
    input  rm_fixed_location, rm_read_base, rm_read_length, rm_go,
    output rm_done,
    input  wm_fixed_location, wm_write_base, wm_write_length, wm_go,
    output wm_done,
    output rdm_fixed_location, rdm_read_base, rdm_read_length, rdm_go,
    input  rdm_done, rdm_early_done,
    output rdm_read_buffer,
    input  rdm_buffer_output_data, rdm_data_available,
    output wrm_fixed_location, wrm_write_base, wrm_write_length, wrm_go,
    input  wrm_done,
    output wrm_write_buffer, wrm_buffer_input_data,
    input  wrm_buffer_full,
    output fifo_used
  );

  modport slave (
    output rm_fixed_location, rm_read_base, rm_read_length, rm_go,
    input  rm_done,
    output wm_fixed_location, wm_write_base, wm_write_length, wm_go,
    input  wm_done,
    input  rdm_fixed_location, rdm_read_base, rdm_read_length, rdm_go,
    output rdm_done, rdm_early_done,
    input  rdm_read_buffer,
    output rdm_buffer_output_data, rdm_data_available,
    input  wrm_fixed_location, wrm_write_base, wrm_write_length, wrm_go,
    output wrm_done,
    input  wrm_write_buffer, wrm_buffer_input_data,
    output wrm_buffer_full,
    input  fifo_used
  );
endinterface

// File: rtl/lpc_stream_copier.sv
// Turns CPU read/write commands into go/base/length jobs on the streaming masters and
// moves read-stream words to the write stream through a show-ahead FIFO.
module lpc_stream_copier #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64
) (
  input logic                 clk,
  input logic                 reset_n,
  lpc_stream_copier_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   USED_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {R_IDLE, R_GO, R_XFER, R_WAIT} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_GO, W_XFER, W_WAIT} wr_state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_used;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;

  rd_state_t             r_rd_state;
  rd_state_t             w_rd_state_nxt;
  logic [30:0]           r_rd_rem;
  logic [30:0]           w_rd_rem_nxt;
  logic                  r_rm_done;
  logic                  w_rm_done_nxt;
  logic                  w_rd_latch;
  logic                  r_rdm_fixed;
  logic [31:0]           r_rdm_base;
  logic [31:0]           r_rdm_len;

  wr_state_t             r_wr_state;
  wr_state_t             w_wr_state_nxt;
  logic [30:0]           r_wr_rem;
  logic [30:0]           w_wr_rem_nxt;
  logic                  r_wm_done;
  logic                  w_wm_done_nxt;
  logic                  w_wr_latch;
  logic                  r_wrm_fixed;
  logic [31:0]           r_wrm_base;
  logic [31:0]           r_wrm_len;

  logic                  w_unused;
  assign w_unused = &{1'b0, bus.rdm_early_done};

  // ---------------- FIFO ----------------
  assign w_fifo_full  = (r_used == FULL_CNT);
  assign w_fifo_empty = (r_used == '0);

  // NOTE: storage has no reset; occupancy is tracked by r_used, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.rdm_buffer_output_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_used <= r_used + USED_ONE;
        2'b01:   r_used <= r_used - USED_ONE;
        default: r_used <= r_used;
      endcase
    end
  end

  // Head is forced to zero when empty so the data output is 0 out of reset.
  assign bus.wrm_buffer_input_data = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.fifo_used             = r_used;

  // ---------------- Read FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state  <= R_IDLE;
      r_rd_rem    <= '0;
      r_rm_done   <= 1'b0;
      r_rdm_fixed <= 1'b0;
      r_rdm_base  <= '0;
      r_rdm_len   <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_rem   <= w_rd_rem_nxt;
      r_rm_done  <= w_rm_done_nxt;
      if (w_rd_latch) begin
        r_rdm_fixed <= bus.rm_fixed_location;
        r_rdm_base  <= bus.rm_read_base;
        r_rdm_len   <= bus.rm_read_length;
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_rem_nxt   = r_rd_rem;
    w_rm_done_nxt  = r_rm_done;
    w_rd_latch     = 1'b0;
    w_push         = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (bus.rm_go) begin
          w_rd_latch   = 1'b1;
          w_rd_rem_nxt = bus.rm_read_length[31:1];
          if (bus.rm_read_length[31:1] == '0) begin
            w_rm_done_nxt = 1'b1;
          end else begin
            w_rm_done_nxt  = 1'b0;
            w_rd_state_nxt = R_GO;
          end
        end
      end
      R_GO: w_rd_state_nxt = R_XFER;
      R_XFER: begin
        w_push = bus.rdm_data_available & ~w_fifo_full & (r_rd_rem != '0);
        if (w_push) begin
          w_rd_rem_nxt = r_rd_rem - 31'd1;
          if (r_rd_rem == 31'd1) w_rd_state_nxt = R_WAIT;
        end
      end
      R_WAIT: begin
        // Only sampled here, well after rdm_go, so the master's idle-high done is ignored.
        if (bus.rdm_done) begin
          w_rm_done_nxt  = 1'b1;
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  assign bus.rdm_go             = (r_rd_state == R_GO);
  assign bus.rdm_read_buffer    = w_push;
  assign bus.rdm_fixed_location = r_rdm_fixed;
  assign bus.rdm_read_base      = r_rdm_base;
  assign bus.rdm_read_length    = r_rdm_len;
  assign bus.rm_done            = r_rm_done;

  // ---------------- Write FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_state  <= W_IDLE;
      r_wr_rem    <= '0;
      r_wm_done   <= 1'b0;
      r_wrm_fixed <= 1'b0;
      r_wrm_base  <= '0;
      r_wrm_len   <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_rem   <= w_wr_rem_nxt;
      r_wm_done  <= w_wm_done_nxt;
      if (w_wr_latch) begin
        r_wrm_fixed <= bus.wm_fixed_location;
        r_wrm_base  <= bus.wm_write_base;
        r_wrm_len   <= bus.wm_write_length;
      end
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_rem_nxt   = r_wr_rem;
    w_wm_done_nxt  = r_wm_done;
    w_wr_latch     = 1'b0;
    w_pop          = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (bus.wm_go) begin
          w_wr_latch   = 1'b1;
          w_wr_rem_nxt = bus.wm_write_length[31:1];
          if (bus.wm_write_length[31:1] == '0) begin
            w_wm_done_nxt = 1'b1;
          end else begin
            w_wm_done_nxt  = 1'b0;
            w_wr_state_nxt = W_GO;
          end
        end
      end
      W_GO: w_wr_state_nxt = W_XFER;
      W_XFER: begin
        w_pop = ~w_fifo_empty & ~bus.wrm_buffer_full & (r_wr_rem != '0);
        if (w_pop) begin
          w_wr_rem_nxt = r_wr_rem - 31'd1;
          if (r_wr_rem == 31'd1) w_wr_state_nxt = W_WAIT;
        end
      end
      W_WAIT: begin
        if (bus.wrm_done) begin
          w_wm_done_nxt  = 1'b1;
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  assign bus.wrm_go             = (r_wr_state == W_GO);
  assign bus.wrm_write_buffer   = w_pop;
  assign bus.wrm_fixed_location = r_wrm_fixed;
  assign bus.wrm_write_base     = r_wrm_base;
  assign bus.wrm_write_length   = r_wrm_len;
  assign bus.wm_done            = r_wm_done;
endmodule

// File: tb/tb_lpc_stream_copier.sv
// Bench for lpc_stream_copier: behavioural read/write masters feed the DUT; a scoreboard
// queue holds the expected write-stream words and a monitor compares each accepted word.
module tb_lpc_stream_copier;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  lpc_stream_copier_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  lpc_stream_copier #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] rd_src [$];
  logic [DW-1:0] exp_q  [$];

  int rd_left = 0, rd_dly = 0, rd_go_cnt = 0, rdm_done_cyc = -10;
  int wr_left = 0, wr_dly = 0, wr_go_cnt = 0, wrm_done_cyc = -10;
  bit rd_pend = 1'b0, wr_pend = 1'b0;
  bit full_toggle = 1'b0;
  int full_ph = 0;
  int wr_cnt = 0, max_used = 0, rm_rise_cyc = -10, wm_rise_cyc = -10;
  bit prev_rm = 1'b0, prev_wm = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit any_output();
    return |{bus.rm_done, bus.wm_done, bus.rdm_fixed_location, bus.rdm_read_base,
             bus.rdm_read_length, bus.rdm_go, bus.rdm_read_buffer, bus.wrm_fixed_location,
             bus.wrm_write_base, bus.wrm_write_length, bus.wrm_go, bus.wrm_write_buffer,
             bus.wrm_buffer_input_data, bus.fifo_used};
  endfunction

  always @(posedge clk) cyc++;

  // Read master model: show-ahead source, done high while idle, done rises after its last word.
  always @(negedge clk) begin
    if (!reset_n) begin
      rd_pend = 1'b0; rd_left = 0; rd_dly = 0;
      bus.rdm_done = 1'b1; bus.rdm_data_available = 1'b0; bus.rdm_buffer_output_data = '0;
    end else begin
      if (rd_pend) begin
        rd_src.delete(0);
        if (rd_left > 0) begin
          rd_left--;
          if (rd_left == 0) rd_dly = 2;
        end
      end
      if (rd_dly > 0) begin
        rd_dly--;
        if (rd_dly == 0) begin bus.rdm_done = 1'b1; rdm_done_cyc = cyc; end
      end
      bus.rdm_data_available     = (rd_src.size() != 0);
      bus.rdm_buffer_output_data = (rd_src.size() != 0) ? rd_src[0] : '0;
      #1;
      rd_pend = bus.rdm_read_buffer;
      if (bus.rdm_go) begin
        rd_go_cnt++;
        rd_left = int'(bus.rdm_read_length[31:1]);
        bus.rdm_done = 1'b0;
      end
    end
  end

  // Write master model: optional full toggling every 3 cycles, done after its last word.
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_pend = 1'b0; wr_left = 0; wr_dly = 0; full_ph = 0;
      bus.wrm_done = 1'b1; bus.wrm_buffer_full = 1'b0;
    end else begin
      if (wr_pend && wr_left > 0) begin
        wr_left--;
        if (wr_left == 0) wr_dly = 2;
      end
      if (wr_dly > 0) begin
        wr_dly--;
        if (wr_dly == 0) begin bus.wrm_done = 1'b1; wrm_done_cyc = cyc; end
      end
      if (full_toggle) begin
        full_ph++;
        if (full_ph == 3) begin full_ph = 0; bus.wrm_buffer_full = ~bus.wrm_buffer_full; end
      end else begin
        bus.wrm_buffer_full = 1'b0;
      end
      #1;
      wr_pend = bus.wrm_write_buffer;
      if (bus.wrm_go) begin
        wr_go_cnt++;
        wr_left = int'(bus.wrm_write_length[31:1]);
        bus.wrm_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor: compares every word the DUT hands to the write master.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (bus.wrm_write_buffer) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("write with empty scoreboard", exp_q.size(), 1);
        else check("write data", bus.wrm_buffer_input_data, exp_q.pop_front());
      end
      if (int'(bus.fifo_used) > max_used) max_used = int'(bus.fifo_used);
      if (bus.rm_done && !prev_rm) rm_rise_cyc = cyc;
      if (bus.wm_done && !prev_wm) wm_rise_cyc = cyc;
    end
    prev_rm = bus.rm_done;
    prev_wm = bus.wm_done;
  end

  task automatic issue(input bit wr, input logic [31:0] base, input logic [31:0] len,
                       input bit fixed, input bit exp_go, input string name);
    logic go, f, d;
    logic [31:0] b, l;
    @(negedge clk);
    if (wr) begin
      bus.wm_write_base = base; bus.wm_write_length = len; bus.wm_fixed_location = fixed;
      bus.wm_go = 1'b1;
    end else begin
      bus.rm_read_base = base; bus.rm_read_length = len; bus.rm_fixed_location = fixed;
      bus.rm_go = 1'b1;
    end
    @(negedge clk);
    bus.wm_go = 1'b0;
    bus.rm_go = 1'b0;
    #2;
    go = wr ? bus.wrm_go : bus.rdm_go;
    b  = wr ? bus.wrm_write_base : bus.rdm_read_base;
    l  = wr ? bus.wrm_write_length : bus.rdm_read_length;
    f  = wr ? bus.wrm_fixed_location : bus.rdm_fixed_location;
    d  = wr ? bus.wm_done : bus.rm_done;
    check({name, " go pulse"}, go, exp_go);
    check({name, " done after go"}, d, !exp_go);
    if (exp_go) begin
      check({name, " base"}, b, base);
      check({name, " length"}, l, len);
      check({name, " fixed"}, f, fixed);
      @(negedge clk); #2;
      check({name, " go one cycle"}, wr ? bus.wrm_go : bus.rdm_go, 1'b0);
    end
  endtask

  task automatic wait_done(input bit wr, input string name);
    int n = 0;
    while (n < 3000 && !(wr ? bus.wm_done : bus.rm_done)) begin
      @(negedge clk); #2;
      n++;
    end
    check({name, " done seen"}, wr ? bus.wm_done : bus.rm_done, 1'b1);
    if (wr) check({name, " done latency"}, wm_rise_cyc, wrm_done_cyc + 1);
    else    check({name, " done latency"}, rm_rise_cyc, rdm_done_cyc + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    int n;
    bus.rm_go = 1'b0; bus.rm_fixed_location = 1'b0; bus.rm_read_base = '0; bus.rm_read_length = '0;
    bus.wm_go = 1'b0; bus.wm_fixed_location = 1'b0; bus.wm_write_base = '0; bus.wm_write_length = '0;
    bus.rdm_early_done = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("reset outputs zero", any_output(), 1'b0);
    check("reset fifo_used", bus.fifo_used, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy: 16 words 0x0001..0x0010.
    rd_go_cnt = 0; wr_go_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      rd_src.push_back(16'(i));
      exp_q.push_back(16'(i));
    end
    issue(1'b0, 32'h1000, 32'd32, 1'b0, 1'b1, "basic rd");
    issue(1'b1, 32'h2000, 32'd32, 1'b0, 1'b1, "basic wr");
    wait_done(1'b0, "basic rd");
    wait_done(1'b1, "basic wr");
    check("basic scoreboard drained", exp_q.size(), 0);
    check("basic rdm_go pulses", rd_go_cnt, 1);
    check("basic wrm_go pulses", wr_go_cnt, 1);
    repeat (3) @(negedge clk);
    #2;
    check("rm_done level held", bus.rm_done, 1'b1);
    check("wm_done level held", bus.wm_done, 1'b1);

    // Backpressure: 128 words read with no writer, then drained against a toggling full.
    for (int i = 0; i < 128; i++) begin
      rd_src.push_back(16'h0100 + 16'(i));
      exp_q.push_back(16'h0100 + 16'(i));
    end
    issue(1'b0, 32'h3000, 32'd256, 1'b0, 1'b1, "bp rd");
    repeat (80) @(negedge clk);
    #2;
    check("bp fifo saturates", bus.fifo_used, DEPTH);
    check("bp read stalled", bus.rdm_read_buffer, 1'b0);
    cnt0 = wr_cnt;
    full_toggle = 1'b1;
    issue(1'b1, 32'h4000, 32'd256, 1'b0, 1'b1, "bp wr");
    wait_done(1'b0, "bp rd");
    wait_done(1'b1, "bp wr");
    full_toggle = 1'b0;
    check("bp words written", wr_cnt - cnt0, 128);
    check("bp scoreboard drained", exp_q.size(), 0);
    check("bp fifo_used max", max_used, DEPTH);
    check("bp fifo empty", bus.fifo_used, 0);

    // Zero length: immediate done, no go pulse.
    rd_go_cnt = 0;
    issue(1'b0, 32'h0, 32'd0, 1'b0, 1'b0, "zero rd");
    repeat (4) @(negedge clk);
    check("zero no rdm_go", rd_go_cnt, 0);

    // Odd length 7: exactly 3 words, one offered word left behind.
    rd_src.push_back(16'h00A1); rd_src.push_back(16'h00A2);
    rd_src.push_back(16'h00A3); rd_src.push_back(16'h00A4);
    issue(1'b0, 32'h7000, 32'd7, 1'b0, 1'b1, "odd rd");
    wait_done(1'b0, "odd rd");
    check("odd words consumed", rd_src.size(), 1);
    check("odd fifo_used", bus.fifo_used, 3);
    rd_src.delete();
    exp_q.push_back(16'h00A1); exp_q.push_back(16'h00A2); exp_q.push_back(16'h00A3);
    issue(1'b1, 32'h7100, 32'd7, 1'b0, 1'b1, "odd wr");
    wait_done(1'b1, "odd wr");
    check("odd scoreboard drained", exp_q.size(), 0);

    // Go while busy: second rm_go in R_XFER is ignored.
    rd_go_cnt = 0;
    for (int i = 1; i <= 8; i++) rd_src.push_back(16'h0B00 + 16'(i));
    issue(1'b0, 32'h1000, 32'd16, 1'b1, 1'b1, "busy rd");
    @(negedge clk);
    bus.rm_read_base = 32'h9000; bus.rm_read_length = 32'd100; bus.rm_fixed_location = 1'b0;
    bus.rm_go = 1'b1;
    @(negedge clk);
    bus.rm_go = 1'b0;
    #2;
    check("busy base kept", bus.rdm_read_base, 32'h1000);
    check("busy length kept", bus.rdm_read_length, 32'd16);
    check("busy fixed kept", bus.rdm_fixed_location, 1'b1);
    wait_done(1'b0, "busy rd");
    check("busy single rdm_go", rd_go_cnt, 1);
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'h0B00 + 16'(i));
    issue(1'b1, 32'h8000, 32'd16, 1'b0, 1'b1, "busy wr");
    wait_done(1'b1, "busy wr");
    check("busy scoreboard drained", exp_q.size(), 0);

    // Write before read: writer idles on empty FIFO until words arrive.
    cnt0 = wr_cnt;
    issue(1'b1, 32'h5000, 32'd8, 1'b0, 1'b1, "early wr");
    repeat (20) @(negedge clk);
    #2;
    check("early wr no words", wr_cnt - cnt0, 0);
    check("early wr strobe low", bus.wrm_write_buffer, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      rd_src.push_back(16'h0C00 + 16'(i));
      exp_q.push_back(16'h0C00 + 16'(i));
    end
    issue(1'b0, 32'h6000, 32'd8, 1'b0, 1'b1, "late rd");
    wait_done(1'b0, "late rd");
    wait_done(1'b1, "early wr");
    check("early wr words", wr_cnt - cnt0, 4);
    check("early scoreboard drained", exp_q.size(), 0);

    // Reset mid-transfer with 10 words buffered.
    for (int i = 0; i < 20; i++) rd_src.push_back(16'h0D00 + 16'(i));
    issue(1'b0, 32'hA000, 32'd40, 1'b0, 1'b1, "abort rd");
    n = 0;
    while (bus.fifo_used != 10 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("abort fifo fill", bus.fifo_used, 10);
    reset_n = 1'b0;
    #1;
    check("abort outputs zero", any_output(), 1'b0);
    check("abort fifo_used", bus.fifo_used, 0);
    repeat (2) @(negedge clk);
    rd_src.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("abort no rm_done", bus.rm_done, 1'b0);
    rd_go_cnt = 0; wr_go_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      rd_src.push_back(16'h0E00 + 16'(i));
      exp_q.push_back(16'h0E00 + 16'(i));
    end
    issue(1'b0, 32'hB000, 32'd8, 1'b0, 1'b1, "post rd");
    issue(1'b1, 32'hC000, 32'd8, 1'b0, 1'b1, "post wr");
    wait_done(1'b0, "post rd");
    wait_done(1'b1, "post wr");
    check("post scoreboard drained", exp_q.size(), 0);
    check("post go pulses", rd_go_cnt + wr_go_cnt, 2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lpc_stream_copier.md
# lpc_stream_copier

Fabric-side responder for the CPU's read-master and write-master command exports (`rm_*` / `wm_*`). It turns each CPU command into a go/base/length transaction on the streaming read master and the streaming write master. Read-stream words pass through an internal FIFO to the write stream, so a DDR-to-DDR block copy runs without CPU data movement. It sits between the PIO command exports and the two Avalon-MM streaming masters in the LPC system.

## Interface

**Parameters**
- `DATA_WIDTH`, 16: stream word width in bits (2 bytes per word).
- `FIFO_DEPTH`, 64: internal FIFO depth in words; must be a power of two.

**Ports**
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `rm_fixed_location` in 1, `rm_read_base` in 32, `rm_read_length` in 32 (bytes): CPU read command fields.
- `rm_go` in 1: CPU read command strobe.
- `rm_done` out 1: read job complete.
- `wm_fixed_location` in 1, `wm_write_base` in 32, `wm_write_length` in 32 (bytes): CPU write command fields.
- `wm_go` in 1: CPU write command strobe.
- `wm_done` out 1: write job complete.
- `rdm_fixed_location` out 1, `rdm_read_base` out 32, `rdm_read_length` out 32, `rdm_go` out 1: read master control outputs.
- `rdm_done` in 1, `rdm_early_done` in 1: read master status; `rdm_early_done` is unused.
- `rdm_read_buffer` out 1, `rdm_buffer_output_data` in DATA_WIDTH, `rdm_data_available` in 1: read stream; the read master's data is show-ahead.
- `wrm_fixed_location` out 1, `wrm_write_base` out 32, `wrm_write_length` out 32, `wrm_go` out 1: write master control outputs.
- `wrm_done` in 1: write master status.
- `wrm_write_buffer` out 1, `wrm_buffer_input_data` out DATA_WIDTH, `wrm_buffer_full` in 1: write stream.
- `fifo_used` out $clog2(FIFO_DEPTH)+1: current internal FIFO occupancy.

## Operation

**Reset**
- All outputs are 0.
- FIFO is empty and both state machines are in IDLE.
- Reset asserted mid-job aborts immediately. No `rm_done` or `wm_done` is produced, and FIFO contents are discarded.

**Read FSM: R_IDLE → R_GO → R_XFER → R_WAIT → R_IDLE**
- R_IDLE, `rm_go`=1:
  - Latch `rm_read_base`, `rm_read_length` and `rm_fixed_location` onto the `rdm_*` outputs.
  - Clear `rm_done`.
  - Load `rd_rem = rm_read_length[31:1]`; word count, bit 0 ignored.
  - If `rd_rem`=0, go straight to R_IDLE, set `rm_done` and do not pulse `rdm_go`.
- R_GO: `rdm_go`=1 for exactly this one cycle.
- R_XFER:
  - `rdm_read_buffer = rdm_data_available & !fifo_full & (rd_rem!=0)`, combinational.
  - Each accepted word is pushed into the FIFO and decrements `rd_rem`.
  - When `rd_rem` reaches 0, go to R_WAIT.
- R_WAIT: when `rdm_done`=1, set `rm_done` and go to R_IDLE.

**Write FSM: W_IDLE → W_GO → W_XFER → W_WAIT → W_IDLE**
- W_IDLE, `wm_go`=1: handled like the read side, with `wr_rem = wm_write_length[31:1]`. Zero length gives an immediate `wm_done` and no `wrm_go`.
- W_GO: `wrm_go` pulses for one cycle.
- W_XFER:
  - `wrm_write_buffer = !fifo_empty & !wrm_buffer_full & (wr_rem!=0)`, combinational.
  - `wrm_buffer_input_data` is the FIFO head, show-ahead.
  - Each accepted word pops the FIFO and decrements `wr_rem`.
  - When `wr_rem` reaches 0, go to W_WAIT.
- W_WAIT: when `wrm_done`=1, set `wm_done` and go to W_IDLE.

**Done flags**
- `rm_done` and `wm_done` are levels.
- Each is set on completion and held until the next accepted go on its side.

**Rules and boundary cases**
- The two FSMs are independent. A write job may start before, during or after its read job; the write stalls on FIFO empty.
- A go arriving while its FSM is not IDLE is ignored, and the latched fields are unchanged.
- FIFO full stalls the read stream; FIFO empty stalls the write stream. Neither condition loses data.
- Simultaneous push and pop on a full FIFO is not possible, because push is gated by `!fifo_full`. On a non-full, non-empty FIFO, push and pop in the same cycle leave `fifo_used` unchanged.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. `fifo_used` ranges from 0 to FIFO_DEPTH.
- Word-count mismatch:
  - If the read length exceeds the write length, the excess words remain in the FIFO. Software must drain them with another write job.
  - If the write length exceeds the read length, the write side waits in W_XFER for more data.

## Timing

- `rm_go` sampled high in R_IDLE at edge N:
  - `rdm_read_base`, `rdm_read_length` and `rdm_fixed_location` are valid from N+1 and held until the next accepted go.
  - `rdm_go`=1 during cycle N+1 only.
  - `rm_done` falls at N+1.
- `rdm_done` is not sampled before R_WAIT, which is at least 2 cycles after the `rdm_go` edge. The master's stale idle-done is therefore never mistaken for completion.
- FIFO latency: a word pushed at edge N is visible on `wrm_buffer_input_data`, and can be popped, from cycle N+1.
- Completion: `rm_done` / `wm_done` rise one cycle after `rdm_done` / `wrm_done` is sampled high in the WAIT state.
- Steady-state throughput is 1 word per cycle when neither stream stalls.

## Test plan

1. **Reset values.** Assert `reset_n`=0 mid-transfer with the FIFO holding 10 words. Required: all outputs 0, `fifo_used`=0, and both FSMs idle after release.
2. **Basic copy.**
   - Stimulus: `rm_go` with base 0x1000, length 32; `wm_go` with base 0x2000, length 32; data 0x0001..0x0010.
   - Required: `rdm_go` and `wrm_go` each high for exactly 1 cycle; base and length mirrored on `rdm_*` / `wrm_*`; 16 words written in order; `rm_done`=1 and `wm_done`=1 one cycle after the respective master done.
3. **Backpressure.**
   - Stimulus: read length 256 with FIFO_DEPTH=64 and write not started.
   - Required: `fifo_used` saturates at 64 and `rdm_read_buffer`=0 while full.
   - Then start the write with `wrm_buffer_full` toggling every 3 cycles. Required: 128 words out, none lost or duplicated.
4. **Zero and odd lengths.**
   - Stimulus: `rm_go` with length 0. Required: no `rdm_go`, `rm_done`=1 on the next cycle.
   - Stimulus: `rm_go` with length 7. Required: exactly 3 words read.
5. **Go while busy.** Send a second `rm_go` with base 0x9000 during R_XFER. Required: ignored, `rdm_read_base` stays 0x1000, and only one `rdm_go` pulse appears.
6. **Write before read.** Send `wm_go` (length 8) 20 cycles before `rm_go` (length 8). Required: `wrm_write_buffer` stays 0 until the first push, then 4 words are written and `wm_done`=1.
